ar_rr_arbiter: RTL and testbench

- Shares one AXI AR request path between `NUM_MASTERS` requesters.
- Selects one pending AR per cycle: highest QoS wins, ties are broken round-robin.
- Tags the ID with the winning master's index and registers the request into a one-entry output stage.
- The output drives the incoming AR request buffer. The master index in the ID lets downstream ordering and R routing return data to the right requester.

---
 rtl/ar_rr_arbiter_if.sv | 43 ++++
 rtl/ar_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_ar_rr_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ar_rr_arbiter_if.sv
// AR request bundle between NUM_MASTERS requesters and the shared AR output stage.
// The slave modport is the arbiter's view, and the master modport is the requester/buffer side.
interface ar_rr_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_WIDTH    = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4
);
    localparam int MIDX_W   = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
    localparam int OUT_ID_W = ID_WIDTH + MIDX_W;

    logic [NUM_MASTERS-1:0]             s_valid;
    logic [NUM_MASTERS-1:0]             s_ready;
    logic [NUM_MASTERS*ID_WIDTH-1:0]    s_id;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0]  s_addr;
    logic [NUM_MASTERS*LEN_WIDTH-1:0]   s_len;
    logic [NUM_MASTERS*SIZE_WIDTH-1:0]  s_size;
    logic [NUM_MASTERS*BURST_WIDTH-1:0] s_burst;
    logic [NUM_MASTERS*QOS_WIDTH-1:0]   s_qos;

    logic                   m_valid;
    logic                   m_ready;
    logic [OUT_ID_W-1:0]    m_id;
    logic [ADDR_WIDTH-1:0]  m_addr;
    logic [LEN_WIDTH-1:0]   m_len;
    logic [SIZE_WIDTH-1:0]  m_size;
    logic [BURST_WIDTH-1:0] m_burst;
    logic [QOS_WIDTH-1:0]   m_qos;
    logic [MIDX_W-1:0]      grant_idx;

    modport slave (
        input  s_valid, s_id, s_addr, s_len, s_size, s_burst, s_qos, m_ready,
        output s_ready, m_valid, m_id, m_addr, m_len, m_size, m_burst, m_qos, grant_idx
    );

    modport master (
        output s_valid, s_id, s_addr, s_len, s_size, s_burst, s_qos, m_ready,
        input  s_ready, m_valid, m_id, m_addr, m_len, m_size, m_burst, m_qos, grant_idx
    );
endinterface

// File: rtl/ar_rr_arbiter.sv
// Arbitrates NUM_MASTERS AR requesters (highest QoS, round-robin tie-break) into a one-entry output register.
// Latency 1 cycle; the winner is ready only when the output stage is empty or popping this cycle.
module ar_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_WIDTH    = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int SIZE_WIDTH  = 3,
    parameter int BURST_WIDTH = 2,
    parameter int QOS_WIDTH   = 4,
    parameter bit QOS_EN      = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    ar_rr_arbiter_if.slave ar
);
    localparam int MIDX_W   = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
    localparam int OUT_ID_W = ID_WIDTH + MIDX_W;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   run_q;
    logic [MIDX_W-1:0]      rr_ptr;
    logic [MIDX_W-1:0]      rr_next;
    logic [MIDX_W-1:0]      win;
    logic                   found;
    logic                   load;
    logic                   accept;
    logic [QOS_WIDTH-1:0]   max_qos;
    logic [NUM_MASTERS-1:0] cand;
    logic [NUM_MASTERS-1:0] s_ready;
    logic                   m_valid;

    logic [OUT_ID_W-1:0]    id_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [SIZE_WIDTH-1:0]  size_q;
    logic [BURST_WIDTH-1:0] burst_q;
    logic [QOS_WIDTH-1:0]   qos_q;
    logic [MIDX_W-1:0]      grant_q;

    always_comb begin
        max_qos = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (ar.s_valid[i] && (ar.s_qos[i*QOS_WIDTH +: QOS_WIDTH] > max_qos))
                max_qos = ar.s_qos[i*QOS_WIDTH +: QOS_WIDTH];
        end
    end

    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand[i] = ar.s_valid[i] &&
                      (!QOS_EN || (ar.s_qos[i*QOS_WIDTH +: QOS_WIDTH] == max_qos));
        end
    end

    // Round-robin scan starting at rr_ptr; the extra index bit absorbs the wrap before reduction.
    always_comb begin
        logic [MIDX_W:0]   idx;
        logic [MIDX_W-1:0] slot;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        slot  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = {1'b0, rr_ptr} + (MIDX_W+1)'(k);
            if (idx >= (MIDX_W+1)'(NUM_MASTERS))
                idx = idx - (MIDX_W+1)'(NUM_MASTERS);
            slot = idx[MIDX_W-1:0];
            if (!found && cand[slot]) begin
                found = 1'b1;
                win   = slot;
            end
        end
    end

    assign load    = (state_q == EMPTY) | ar.m_ready;
    assign accept  = load & run_q & found;
    assign rr_next = (win == MIDX_W'(NUM_MASTERS - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (ar.m_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        m_valid = (state_q == FULL);
        s_ready = '0;
        if (accept)
            s_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            rr_ptr  <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            qos_q   <= '0;
            grant_q <= '0;
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                rr_ptr  <= rr_next;
                id_q    <= {win, ar.s_id[win*ID_WIDTH +: ID_WIDTH]};
                addr_q  <= ar.s_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                len_q   <= ar.s_len[win*LEN_WIDTH +: LEN_WIDTH];
                size_q  <= ar.s_size[win*SIZE_WIDTH +: SIZE_WIDTH];
                burst_q <= ar.s_burst[win*BURST_WIDTH +: BURST_WIDTH];
                qos_q   <= ar.s_qos[win*QOS_WIDTH +: QOS_WIDTH];
                grant_q <= win;
            end
        end
    end

    assign ar.s_ready   = s_ready;
    assign ar.m_valid   = m_valid;
    assign ar.m_id      = id_q;
    assign ar.m_addr    = addr_q;
    assign ar.m_len     = len_q;
    assign ar.m_size    = size_q;
    assign ar.m_burst   = burst_q;
    assign ar.m_qos     = qos_q;
    assign ar.grant_idx = grant_q;
endmodule

// File: tb/tb_ar_rr_arbiter.sv
// Directed table-driven bench for ar_rr_arbiter: a 4-master QoS instance, a 4-master pure round-robin instance
// and a 3-master instance, plus hand sequences for reset and wrap behaviour.
module tb_ar_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    ar_rr_arbiter_if #(.NUM_MASTERS(4)) if0 ();
    ar_rr_arbiter_if #(.NUM_MASTERS(4)) if1 ();
    ar_rr_arbiter_if #(.NUM_MASTERS(3)) if2 ();

    ar_rr_arbiter #(.NUM_MASTERS(4), .QOS_EN(1'b1)) u_dut    (.clk(clk), .rst_n(rst_n), .ar(if0));
    ar_rr_arbiter #(.NUM_MASTERS(4), .QOS_EN(1'b0)) u_dut_nq (.clk(clk), .rst_n(rst_n), .ar(if1));
    ar_rr_arbiter #(.NUM_MASTERS(3), .QOS_EN(1'b1)) u_dut3   (.clk(clk), .rst_n(rst_n), .ar(if2));

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] qos;
        logic        m_ready;
        logic [3:0]  exp_ready;
        logic        exp_mv;
        logic [1:0]  exp_grant;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] valid, input logic [15:0] qos, input logic m_ready,
                                input logic [3:0] exp_ready, input logic exp_mv, input logic [1:0] exp_grant);
        vec_t v;
        v.valid = valid; v.qos = qos; v.m_ready = m_ready;
        v.exp_ready = exp_ready; v.exp_mv = exp_mv; v.exp_grant = exp_grant;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [9:0] exp_id(input logic [1:0] g);
        return {g, 8'h10 + {6'd0, g}};
    endfunction

    function automatic logic [31:0] exp_addr(input logic [1:0] g);
        return 32'hA000_0000 | {22'd0, g, 8'd0};
    endfunction

    task automatic run_row(input vec_t v, input int n);
        @(negedge clk);
        if0.s_valid = v.valid;
        if0.s_qos   = v.qos;
        if0.m_ready = v.m_ready;
        #1;
        chk($sformatf("row%0d s_ready", n), 64'(if0.s_ready), 64'(v.exp_ready));
        @(posedge clk);
        #1;
        chk($sformatf("row%0d m_valid", n), 64'(if0.m_valid), 64'(v.exp_mv));
        chk($sformatf("row%0d grant_idx", n), 64'(if0.grant_idx), 64'(v.exp_grant));
        if (v.exp_mv) begin
            chk($sformatf("row%0d m_id", n), 64'(if0.m_id), 64'(exp_id(v.exp_grant)));
            chk($sformatf("row%0d m_addr", n), 64'(if0.m_addr), 64'(exp_addr(v.exp_grant)));
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            if0.s_id[i*8 +: 8]     = 8'(16 + i);
            if0.s_addr[i*32 +: 32] = 32'hA000_0000 | (32'(i) << 8);
            if0.s_len[i*8 +: 8]    = 8'(i + 1);
            if0.s_size[i*3 +: 3]   = 3'(i);
            if0.s_burst[i*2 +: 2]  = 2'd1;
            if1.s_id[i*8 +: 8]     = 8'(16 + i);
            if1.s_addr[i*32 +: 32] = 32'hA000_0000 | (32'(i) << 8);
            if1.s_len[i*8 +: 8]    = 8'(i + 1);
            if1.s_size[i*3 +: 3]   = 3'(i);
            if1.s_burst[i*2 +: 2]  = 2'd1;
        end
        for (int i = 0; i < 3; i++) begin
            if2.s_id[i*8 +: 8]     = 8'(16 + i);
            if2.s_addr[i*32 +: 32] = 32'hA000_0000 | (32'(i) << 8);
            if2.s_len[i*8 +: 8]    = 8'(i + 1);
            if2.s_size[i*3 +: 3]   = 3'(i);
            if2.s_burst[i*2 +: 2]  = 2'd1;
        end
        if0.s_valid = 4'hF; if0.s_qos = '0; if0.m_ready = 1'b1;
        if1.s_valid = '0;   if1.s_qos = '0; if1.m_ready = 1'b1;
        if2.s_valid = '0;   if2.s_qos = '0; if2.m_ready = 1'b1;

        // Rows start with master 0 held in the output stage and rr_ptr = 1.
        add(4'hF, 16'h0000, 1'b1, 4'b0010, 1'b1, 2'd1);
        add(4'hF, 16'h0000, 1'b1, 4'b0100, 1'b1, 2'd2);
        add(4'hF, 16'h0000, 1'b1, 4'b1000, 1'b1, 2'd3);
        add(4'hF, 16'h0000, 1'b1, 4'b0001, 1'b1, 2'd0);
        add(4'hF, 16'h0000, 1'b1, 4'b0010, 1'b1, 2'd1);
        add(4'h1, 16'h0000, 1'b1, 4'b0001, 1'b1, 2'd0);
        add(4'hA, 16'h9020, 1'b1, 4'b1000, 1'b1, 2'd3);
        add(4'h2, 16'h9020, 1'b1, 4'b0010, 1'b1, 2'd1);
        add(4'hA, 16'h2090, 1'b1, 4'b0010, 1'b1, 2'd1);
        add(4'hA, 16'h5050, 1'b1, 4'b1000, 1'b1, 2'd3);
        add(4'h0, 16'h0000, 1'b1, 4'b0000, 1'b0, 2'd3);
        add(4'h0, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd3);
        add(4'h4, 16'h0000, 1'b0, 4'b0100, 1'b1, 2'd2);
        for (int i = 0; i < 5; i++)
            add(4'hF, 16'h0000, 1'b0, 4'b0000, 1'b1, 2'd2);
        add(4'hF, 16'h0000, 1'b1, 4'b1000, 1'b1, 2'd3);
        add(4'h0, 16'h0000, 1'b0, 4'b0000, 1'b1, 2'd3);

        // Reset with all masters requesting, then first grant.
        repeat (2) @(posedge clk);
        #1;
        chk("rst m_valid", 64'(if0.m_valid), 64'd0);
        chk("rst s_ready", 64'(if0.s_ready), 64'd0);
        chk("rst grant_idx", 64'(if0.grant_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-rst s_ready", 64'(if0.s_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("first edge m_valid", 64'(if0.m_valid), 64'd0);
        chk("first grant s_ready", 64'(if0.s_ready), 64'b0001);
        @(posedge clk);
        #1;
        chk("first grant m_valid", 64'(if0.m_valid), 64'd1);
        chk("first grant m_id", 64'(if0.m_id), 64'(exp_id(2'd0)));

        foreach (vecs[i]) run_row(vecs[i], i);

        // Pure round-robin: QoS is ignored.
        @(negedge clk);
        if1.s_valid = 4'h1;
        #1;
        chk("nq m0 s_ready", 64'(if1.s_ready), 64'b0001);
        @(posedge clk);
        #1;
        chk("nq m0 grant", 64'(if1.grant_idx), 64'd0);
        @(negedge clk);
        if1.s_valid = 4'hA;
        if1.s_qos   = 16'h9020;
        #1;
        chk("nq rr1 s_ready", 64'(if1.s_ready), 64'b0010);
        @(posedge clk);
        #1;
        chk("nq rr1 m_id", 64'(if1.m_id), 64'(exp_id(2'd1)));
        @(negedge clk);
        #1;
        chk("nq rr2 s_ready", 64'(if1.s_ready), 64'b1000);
        @(posedge clk);
        #1;
        chk("nq rr2 grant", 64'(if1.grant_idx), 64'd3);
        if1.s_valid = '0;

        // Three masters: wrap after granting master 2.
        @(negedge clk);
        if2.s_valid = 3'b100;
        #1;
        chk("n3 m2 s_ready", 64'(if2.s_ready), 64'b100);
        @(posedge clk);
        #1;
        chk("n3 m2 grant", 64'(if2.grant_idx), 64'd2);
        chk("n3 rr_ptr wrap", 64'(u_dut3.rr_ptr), 64'd0);
        @(negedge clk);
        if2.s_valid = 3'b101;
        #1;
        chk("n3 wrap s_ready", 64'(if2.s_ready), 64'b001);
        @(posedge clk);
        #1;
        chk("n3 wrap m_id", 64'(if2.m_id), 64'({2'd0, 8'h10}));
        @(negedge clk);
        #1;
        chk("n3 next s_ready", 64'(if2.s_ready), 64'b100);
        @(posedge clk);
        #1;
        chk("n3 next grant", 64'(if2.grant_idx), 64'd2);
        if2.s_valid = '0;

        // Asynchronous reset while full and stalled.
        chk("pre-rst stalled m_valid", 64'(if0.m_valid), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst m_valid", 64'(if0.m_valid), 64'd0);
        chk("async rst grant_idx", 64'(if0.grant_idx), 64'd0);
        chk("async rst m_id", 64'(if0.m_id), 64'd0);
        if0.s_valid = 4'hF;
        if0.m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("in rst m_valid", 64'(if0.m_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rerelease s_ready", 64'(if0.s_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rerelease m_valid", 64'(if0.m_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("restart m_valid", 64'(if0.m_valid), 64'd1);
        chk("restart m_id", 64'(if0.m_id), 64'(exp_id(2'd0)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
